// File: rtl/timer_disp_pkg.sv
// Shared types and seven-segment constants for the timer display scanner.
package timer_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV_MIN, CONV_SEC, COMMIT} conv_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns {g,f,e,d,c,b,a}; element 9 is the leftmost entry.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes go blank.
module bcd_seg_decode
  import timer_disp_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_LUT[bcd];
  end

endmodule

// File: rtl/timer_display_scan.sv
// Converts the packed mm:ss timer value to BCD and scans it onto a 4-digit
// multiplexed seven-segment display with colon point and time-up blinking.
module timer_display_scan
  import timer_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [11:0] timer_in,
  input  logic        time_up,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic [3:0]  digit_en,
  output logic        dp,
  output logic        busy
);

  localparam logic [15:0] PRES_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  conv_state_t state, state_nxt;
  logic [11:0] captured;
  logic [5:0]  work;
  logic [2:0]  tens;
  bcd_t        min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;
  bcd_t        disp [4];

  logic [15:0] pres;
  logic [1:0]  idx;
  logic        frame_end;
  logic [7:0]  frame_cnt;
  logic        blink_on;
  logic [6:0]  seg_dec;

  // ---- conversion FSM: state register ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- conversion FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (timer_in != captured) state_nxt = CONV_MIN;
      CONV_MIN: if (work < 6'd10)         state_nxt = CONV_SEC;
      CONV_SEC: if (work < 6'd10)         state_nxt = COMMIT;
      COMMIT:                             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // ---- conversion FSM: outputs ----
  always_comb begin
    busy = (state != IDLE);
  end

  // Repeated subtraction; staged digits only reach the display in COMMIT so a
  // half-converted value is never scanned out.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      captured   <= '0;
      work       <= '0;
      tens       <= '0;
      min_tens_s <= '0;
      min_ones_s <= '0;
      sec_tens_s <= '0;
      sec_ones_s <= '0;
      for (int i = 0; i < 4; i++) disp[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (timer_in != captured) begin
            captured <= timer_in;
            work     <= timer_in[11:6];
            tens     <= '0;
          end
        end
        CONV_MIN: begin
          if (work >= 6'd10) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            min_tens_s <= {1'b0, tens};
            min_ones_s <= work[3:0];
            work       <= captured[5:0];
            tens       <= '0;
          end
        end
        CONV_SEC: begin
          if (work >= 6'd10) begin
            work <= work - 6'd10;
            tens <= tens + 3'd1;
          end else begin
            sec_tens_s <= {1'b0, tens};
            sec_ones_s <= work[3:0];
          end
        end
        COMMIT: begin
          disp[0] <= sec_ones_s;
          disp[1] <= sec_tens_s;
          disp[2] <= min_ones_s;
          disp[3] <= min_tens_s;
        end
        default: ;
      endcase
    end
  end

  // ---- scan prescaler and digit index ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pres <= '0;
      idx  <= '0;
    end else if (pres == PRES_LAST) begin
      pres <= '0;
      idx  <= idx + 2'd1;
    end else begin
      pres <= pres + 16'd1;
    end
  end

  assign frame_end = (pres == PRES_LAST) && (idx == 2'd3);

  // ---- blink phase, frozen on while the timer is still running ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!time_up) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  bcd_seg_decode u_dec (
    .bcd (disp[idx]),
    .seg (seg_dec)
  );

  // ---- registered display drive ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg      <= SEG_BLANK;
      digit_en <= '0;
      dp       <= 1'b0;
    end else if (!enable || !blink_on) begin
      seg      <= SEG_BLANK;
      digit_en <= '0;
      dp       <= 1'b0;
    end else begin
      digit_en <= 4'b0001 << idx;
      dp       <= (idx == 2'd2);
      seg      <= (idx == 2'd3 && disp[3] == 4'd0) ? SEG_BLANK : seg_dec;
    end
  end

endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized bench for timer_display_scan against an arithmetic reference model.
module tb_timer_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [11:0] timer_in = '0;
  logic        time_up = 1'b0;
  logic        enable = 1'b1;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        dp;
  logic        busy;

  int checks = 0;
  int failures = 0;

  timer_display_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .timer_in (timer_in),
    .time_up  (time_up),
    .enable   (enable),
    .seg      (seg),
    .digit_en (digit_en),
    .dp       (dp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {seg, digit_en, dp} for a shown mm:ss value in a given slot.
  function automatic logic [11:0] exp_out(input logic [11:0] shown, input int slot,
                                          input logic en, input logic on);
    int mins, secs, d;
    logic [6:0] s;
    if (!en || !on) return 12'h000;
    mins = int'(shown[11:6]);
    secs = int'(shown[5:0]);
    case (slot)
      0:       d = secs % 10;
      1:       d = secs / 10;
      2:       d = mins % 10;
      default: d = mins / 10;
    endcase
    s = (slot == 3 && d == 0) ? 7'h00 : seg_of(d);
    return {s, 4'(1 << slot), (slot == 2)};
  endfunction

  // Busy cycles for one conversion: each field takes (value/10 + 1) cycles, plus commit.
  function automatic int conv_len(input logic [11:0] v);
    return (int'(v[11:6]) / 10 + 1) + (int'(v[5:0]) / 10 + 1) + 1;
  endfunction

  int          m_t, m_rem, m_nfe;
  logic [11:0] m_cap, m_pend, m_shown;
  logic [11:0] m_exp;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_t     <= 0;
      m_rem   <= 0;
      m_nfe   <= 0;
      m_cap   <= '0;
      m_pend  <= '0;
      m_shown <= '0;
      m_exp   <= '0;
    end else begin
      m_exp <= exp_out(m_shown, (m_t / SCAN_DIV) % 4, enable,
                       ((m_nfe / BLINK_FRAMES) % 2) == 0);
      m_t <= m_t + 1;
      if (m_rem == 0) begin
        if (timer_in != m_cap) begin
          m_cap  <= timer_in;
          m_pend <= timer_in;
          m_rem  <= conv_len(timer_in);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_shown <= m_pend;
      end
      if (!time_up)                           m_nfe <= 0;
      else if (m_t % FRAME_CYC == FRAME_CYC - 1) m_nfe <= m_nfe + 1;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("seg",      int'(seg),      int'(m_exp[11:5]));
      chk("digit_en", int'(digit_en), int'(m_exp[4:1]));
      chk("dp",       int'(dp),       int'(m_exp[0]));
      chk("busy",     int'(busy),     int'(m_rem != 0));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg",      int'(seg),      0);
    chk("rst_digit_en", int'(digit_en), 0);
    chk("rst_dp",       int'(dp),       0);
    chk("rst_busy",     int'(busy),     0);
    nrst = 1'b1;

    step(1);
    chk("first_digit_en", int'(digit_en), 1);
    chk("first_seg",      int'(seg),      'h3F);
    step(2 * FRAME_CYC);

    timer_in = {6'd5, 6'd25};
    step(3 * FRAME_CYC);

    timer_in = {6'd63, 6'd63};
    step(4);
    timer_in = '0;
    step(4 * FRAME_CYC);

    timer_in = {6'd41, 6'd7};
    step(2 * FRAME_CYC);
    time_up = 1'b1;
    step(10 * FRAME_CYC);
    time_up = 1'b0;
    step(FRAME_CYC);

    enable = 1'b0;
    timer_in = {6'd12, 6'd34};
    step(2 * FRAME_CYC);
    enable = 1'b1;
    step(FRAME_CYC);

    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) timer_in = 12'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) time_up = ~time_up;
      step(1);
    end

    enable = 1'b1;
    time_up = 1'b0;
    step(20);
    timer_in = {6'd63, 6'd0};
    step(3);
    chk("pre_rst_busy", int'(busy), 1);
    #2 nrst = 1'b0;
    #1;
    chk("async_seg",      int'(seg),      0);
    chk("async_digit_en", int'(digit_en), 0);
    chk("async_dp",       int'(dp),       0);
    chk("async_busy",     int'(busy),     0);
    timer_in = '0;
    @(negedge clk);
    nrst = 1'b1;
    step(2 * FRAME_CYC);
    timer_in = {6'd7, 6'd9};
    step(2 * FRAME_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
